sap1_controller: RTL and testbench

Controller-sequencer for the SAP-1 datapath. It sits directly upstream of the ALU and drives that ALU's `sub` and `out_en` inputs, along with every other load and enable strobe on the shared 8-bit bus. A 6-state one-hot ring counter steps through fetch (T1–T3) and execute (T4–T6). In the execute states it decodes the 4-bit opcode held in the instruction register and produces a control word each cycle. It supports LDA, ADD, SUB, OUT and HLT; every other opcode is treated as a NOP.

---
 rtl/sap1_controller.sv | 135 +++++++++++++
 tb/tb_sap1_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: a one-hot six-state ring counter (T1..T6)
// plus a combinational control-word decoder for LDA, ADD, SUB, OUT and HLT.
// All other opcodes execute as a six-cycle NOP.
module sap1_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       halted,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_sub,
  output logic       alu_out,
  output logic       out_load
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t state;
  state_t state_next;
  logic   halted_next;

  assign t_state = state;

  // Ring counter and sticky halt flag; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= T1;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= halted_next;
    end
  end

  // Next-state: advance the ring, freeze at T4 on HLT, recover any
  // non-one-hot pattern to T1.
  always_comb begin
    state_next  = T1;
    halted_next = halted;
    case (state)
      T1: state_next = T2;
      T2: state_next = T3;
      T3: state_next = T4;
      T4: begin
        if (halted || opcode == OP_HLT) begin
          state_next  = T4;
          halted_next = 1'b1;
        end else begin
          state_next  = T5;
        end
      end
      T5: state_next = T6;
      T6: state_next = T1;
      default: state_next = T1;
    endcase
  end

  // Control-word decode; reset and halt silence every strobe. Each state
  // enables at most one bus driver, so the bus never sees contention.
  always_comb begin
    pc_inc   = 1'b0;
    pc_out   = 1'b0;
    mar_load = 1'b0;
    ram_out  = 1'b0;
    ir_load  = 1'b0;
    ir_out   = 1'b0;
    a_load   = 1'b0;
    a_out    = 1'b0;
    b_load   = 1'b0;
    alu_sub  = 1'b0;
    alu_out  = 1'b0;
    out_load = 1'b0;
    if (!rst && !halted) begin
      case (state)
        T1: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T2: pc_inc = 1'b1;
        T3: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
        end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            ir_out   = 1'b1;
            mar_load = 1'b1;
          end else if (opcode == OP_OUT) begin
            a_out    = 1'b1;
            out_load = 1'b1;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            ram_out = 1'b1;
            a_load  = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ram_out = 1'b1;
            b_load  = 1'b1;
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out = 1'b1;
            a_load  = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_controller.sv
// Directed bench for sap1_controller with a small SAP-1 datapath model
// (PC, MAR, RAM, IR, A, B, ALU, output register) driven by the strobes.
module tb_sap1_controller;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic       halted;
  logic       pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out;
  logic       a_load, a_out, b_load, alu_sub, alu_out, out_load;

  sap1_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .t_state(t_state), .halted(halted),
    .pc_inc(pc_inc), .pc_out(pc_out), .mar_load(mar_load), .ram_out(ram_out),
    .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load), .a_out(a_out),
    .b_load(b_load), .alu_sub(alu_sub), .alu_out(alu_out), .out_load(out_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe vector bit order:
  // pc_inc pc_out mar_load ram_out ir_load ir_out a_load a_out b_load alu_sub alu_out out_load
  logic [11:0] strobes;
  assign strobes = {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
                    a_load, a_out, b_load, alu_sub, alu_out, out_load};

  localparam logic [11:0] S0     = 12'h000;
  localparam logic [11:0] S_T1   = 12'h600;
  localparam logic [11:0] S_T2   = 12'h800;
  localparam logic [11:0] S_T3   = 12'h180;
  localparam logic [11:0] S_IRM  = 12'h240;
  localparam logic [11:0] S_RA   = 12'h120;
  localparam logic [11:0] S_RB   = 12'h108;
  localparam logic [11:0] S_ADD6 = 12'h022;
  localparam logic [11:0] S_SUB6 = 12'h026;
  localparam logic [11:0] S_OUT4 = 12'h011;

  localparam logic [5:0] T1 = 6'b000001, T2 = 6'b000010, T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000, T5 = 6'b010000, T6 = 6'b100000;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic [5:0]  t;
    logic        h;
    logic [11:0] s;
    logic [7:0]  a;
  } vec_t;

  vec_t vecs[$];

  // Datapath model
  logic [3:0] pc, mar;
  logic [7:0] ram [16];
  logic [7:0] ir, areg, breg, outr, bus;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] op, input logic [5:0] et,
                      input logic eh, input logic [11:0] es, input logic [7:0] ea,
                      input string tag);
    @(negedge clk);
    rst = r;
    opcode = op;
    #1;
    chk({tag, " t_state"}, {6'd0, t_state}, {6'd0, et});
    chk({tag, " halted"}, {11'd0, halted}, {11'd0, eh});
    chk({tag, " strobes"}, strobes, es);
    chk({tag, " A"}, {4'd0, areg}, {4'd0, ea});
    checks++;
    if ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) begin
      errors++;
      $display("FAIL %s bus: drivers %b, expected at most one",
               tag, {pc_out, ram_out, ir_out, a_out, alu_out});
    end
    // Apply the register loads of the edge that ends this cycle.
    bus = 8'h00;
    if (pc_out)  bus = {4'h0, pc};
    if (ram_out) bus = ram[mar];
    if (ir_out)  bus = {4'h0, ir[3:0]};
    if (a_out)   bus = areg;
    if (alu_out) bus = alu_sub ? (areg - breg) : (areg + breg);
    if (r) pc = 4'h0;
    else if (pc_inc) pc = pc + 4'h1;
    if (mar_load) mar  = bus[3:0];
    if (ir_load)  ir   = bus;
    if (a_load)   areg = bus;
    if (b_load)   breg = bus;
    if (out_load) outr = bus;
  endtask

  task automatic add_instr(input logic [3:0] op, input logic [11:0] s4,
                           input logic [11:0] s5, input logic [11:0] s6,
                           input logic [7:0] a0, input logic [7:0] a6);
    // Opcode is scrambled during fetch; it must have no effect there.
    vecs.push_back('{1'b0, 4'h7, T1, 1'b0, S_T1, a0});
    vecs.push_back('{1'b0, 4'hF, T2, 1'b0, S_T2, a0});
    vecs.push_back('{1'b0, 4'h3, T3, 1'b0, S_T3, a0});
    vecs.push_back('{1'b0, op,   T4, 1'b0, s4,   a0});
    vecs.push_back('{1'b0, op,   T5, 1'b0, s5,   a0});
    vecs.push_back('{1'b0, op,   T6, 1'b0, s6,   a6});
  endtask

  initial begin
    rst = 1'b1;
    opcode = 4'h0;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    ram[0] = 8'h1A;  // ADD A
    ram[1] = 8'h2A;  // SUB A
    ram[2] = 8'h09;  // LDA 9
    ram[3] = 8'h50;  // NOP
    ram[4] = 8'hE0;  // OUT
    ram[5] = 8'hF0;  // HLT
    ram[9] = 8'h2C;
    ram[10] = 8'h03;
    pc = 4'h0; mar = 4'h0; ir = 8'h00;
    areg = 8'h07; breg = 8'h00; outr = 8'h00; bus = 8'h00;

    vecs.push_back('{1'b1, 4'h0, T1, 1'b0, S0, 8'h07});
    vecs.push_back('{1'b1, 4'h0, T1, 1'b0, S0, 8'h07});
    add_instr(4'h1, S_IRM, S_RB, S_ADD6, 8'h07, 8'h07);  // A -> 0A at end
    add_instr(4'h2, S_IRM, S_RB, S_SUB6, 8'h0A, 8'h0A);  // A -> 07
    add_instr(4'h0, S_IRM, S_RA, S0,     8'h07, 8'h2C);  // A -> 2C in T5
    add_instr(4'h5, S0,    S0,   S0,     8'h2C, 8'h2C);
    add_instr(4'hE, S_OUT4, S0,  S0,     8'h2C, 8'h2C);
    // LDA T5 loads A, so T6 already sees 2C; fix that row's T5 expectation.
    vecs[18].a = 8'h07;
    vecs[19].a = 8'h2C;

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].op, vecs[i].t, vecs[i].h, vecs[i].s, vecs[i].a,
           $sformatf("row%0d", i));
    chk("out register", {4'd0, outr}, 12'h02C);

    // HLT: fetch, T4 with no strobes, then frozen.
    step(1'b0, 4'h2, T1, 1'b0, S_T1, 8'h2C, "hlt T1");
    step(1'b0, 4'h1, T2, 1'b0, S_T2, 8'h2C, "hlt T2");
    step(1'b0, 4'h0, T3, 1'b0, S_T3, 8'h2C, "hlt T3");
    step(1'b0, 4'hF, T4, 1'b0, S0,   8'h2C, "hlt T4");
    for (int i = 0; i < 20; i++)
      step(1'b0, 4'($urandom_range(0, 15)), T4, 1'b1, S0, 8'h2C,
           $sformatf("halted%0d", i));

    // Reset while halted, then reset in the middle of ADD T5.
    step(1'b1, 4'h1, T4, 1'b1, S0, 8'h2C, "rst halted");
    step(1'b0, 4'h7, T1, 1'b0, S_T1, 8'h2C, "resume T1");
    step(1'b0, 4'h7, T2, 1'b0, S_T2, 8'h2C, "resume T2");
    step(1'b0, 4'h7, T3, 1'b0, S_T3, 8'h2C, "resume T3");
    step(1'b0, 4'h1, T4, 1'b0, S_IRM, 8'h2C, "add T4");
    breg = 8'hEE;
    step(1'b1, 4'h1, T5, 1'b0, S0, 8'h2C, "rst in T5");
    step(1'b0, 4'h1, T1, 1'b0, S_T1, 8'h2C, "post rst T1");
    chk("B untouched", {4'd0, breg}, 12'h0EE);
    step(1'b0, 4'h1, T2, 1'b0, S_T2, 8'h2C, "readd T2");
    step(1'b0, 4'h1, T3, 1'b0, S_T3, 8'h2C, "readd T3");
    step(1'b0, 4'h1, T4, 1'b0, S_IRM, 8'h2C, "readd T4");
    step(1'b0, 4'h1, T5, 1'b0, S_RB, 8'h2C, "readd T5");
    step(1'b0, 4'h1, T6, 1'b0, S_ADD6, 8'h2C, "readd T6");
    step(1'b0, 4'h2, T1, 1'b0, S_T1, 8'h2F, "after readd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
